// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master arbiter FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [3:0] HPROT_FETCH = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_LAST = 2'b10,
        ST_ERR  = 2'b11
    } ahb_state_e;

    // Line length in beats to the matching incrementing burst code.
    function automatic logic [2:0] burst_code(input int words);
        case (words)
            32'sd4:  burst_code = HBURST_INCR4;
            32'sd16: burst_code = HBURST_INCR16;
            default: burst_code = HBURST_INCR8;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Two-way round-robin grant between I and D sides; the last-granted side
// only advances when a grant is actually taken.
module ahb_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic gnt_valid,
    output logic gnt_d
);

    logic last_d_r;

    assign gnt_valid = en & (i_req | d_req);
    // On a tie the side not served last wins; after reset I counts as last.
    assign gnt_d     = d_req & (~i_req | ~last_d_r);

    // Last-granted side register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if (gnt_valid) begin
            last_d_r <= gnt_d;
        end else begin
            last_d_r <= last_d_r;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Merges I-side and D-side cache requests onto one AHB-Lite master port,
// with pipelined address/data phases, wait states and two-cycle ERROR handling.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_burst,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_burst,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    output logic        d_wnext,
    output logic [31:0] i_rdata,
    output logic [31:0] d_rdata,
    output logic        i_rvalid,
    output logic        d_rvalid,
    output logic        i_done,
    output logic        d_done,
    output logic        i_err,
    output logic        d_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    ahb_state_e state_r, state_nxt_s;
    logic       side_d_r, dphase_r;
    logic [3:0] cnt_r;
    logic       gnt_valid_s, gnt_d_s, gnt_burst_s;
    logic       grant_s, accept_s, beat_ok_s, finish_s, err_start_s, err_end_s;

    // A side whose done is pulsing this cycle may still show req; don't re-grant it.
    ahb_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (state_r == ST_IDLE),
        .i_req     (i_req & ~i_done),
        .d_req     (d_req & ~d_done),
        .gnt_valid (gnt_valid_s),
        .gnt_d     (gnt_d_s)
    );

    assign gnt_burst_s = gnt_d_s ? d_burst : i_burst;
    assign d_wnext     = accept_s & side_d_r & HWRITE;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle bus event decode.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        accept_s    = 1'b0;
        beat_ok_s   = 1'b0;
        finish_s    = 1'b0;
        err_start_s = 1'b0;
        err_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (dphase_r && HRESP && !HREADY) begin
                    err_start_s = 1'b1;
                    state_nxt_s = ST_ERR;
                end else if (HREADY) begin
                    accept_s    = 1'b1;
                    beat_ok_s   = dphase_r & ~HRESP;
                    state_nxt_s = (cnt_r == 4'd0) ? ST_LAST : ST_XFER;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_LAST: begin
                if (HRESP && !HREADY) begin
                    err_start_s = 1'b1;
                    state_nxt_s = ST_ERR;
                end else if (HREADY) begin
                    beat_ok_s   = ~HRESP;
                    finish_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LAST;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    err_end_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus outputs, beat counter and requester acknowledges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_d_r  <= 1'b0;
            dphase_r  <= 1'b0;
            cnt_r     <= 4'd0;
            HADDR     <= 32'h0000_0000;
            HTRANS    <= HTRANS_IDLE;
            HBURST    <= HBURST_SINGLE;
            HSIZE     <= HSIZE_WORD;
            HPROT     <= HPROT_DATA;
            HMASTLOCK <= 1'b0;
            HWRITE    <= 1'b0;
            HWDATA    <= 32'h0000_0000;
            i_rdata   <= 32'h0000_0000;
            d_rdata   <= 32'h0000_0000;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            HSIZE     <= HSIZE_WORD;
            HMASTLOCK <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
            if (grant_s) begin
                side_d_r <= gnt_d_s;
                dphase_r <= 1'b0;
                cnt_r    <= gnt_burst_s ? 4'(LINE_WORDS - 1) : 4'd0;
                HADDR    <= gnt_d_s ? d_addr : i_addr;
                HTRANS   <= HTRANS_NONSEQ;
                HBURST   <= gnt_burst_s ? burst_code(LINE_WORDS) : HBURST_SINGLE;
                HPROT    <= gnt_d_s ? HPROT_DATA : HPROT_FETCH;
                HWRITE   <= gnt_d_s & d_write;
            end else if (accept_s) begin
                dphase_r <= 1'b1;
                if (HWRITE) begin
                    HWDATA <= d_wdata;
                end
                if (cnt_r == 4'd0) begin
                    HTRANS <= HTRANS_IDLE;
                end else begin
                    HTRANS <= HTRANS_SEQ;
                    HADDR  <= HADDR + 32'd4;
                    cnt_r  <= cnt_r - 4'd1;
                end
            end else if (err_start_s || finish_s) begin
                dphase_r <= 1'b0;
                HTRANS   <= HTRANS_IDLE;
            end
            if (beat_ok_s && !HWRITE) begin
                if (side_d_r) begin
                    d_rdata  <= HRDATA;
                    d_rvalid <= 1'b1;
                end else begin
                    i_rdata  <= HRDATA;
                    i_rvalid <= 1'b1;
                end
            end
            if (finish_s || err_end_s) begin
                if (side_d_r) begin
                    d_done <= 1'b1;
                    d_err  <= err_end_s;
                end else begin
                    i_done <= 1'b1;
                    i_err  <= err_end_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: cycle 0 is the cycle a request is
// first presented; outputs are sampled on the falling edge.
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_burst, d_req, d_burst, d_write;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        d_wnext, i_rvalid, d_rvalid, i_done, d_done, i_err, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic [3:0]  HPROT;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.LINE_WORDS(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst),
        .d_req(d_req), .d_addr(d_addr), .d_burst(d_burst), .d_write(d_write),
        .d_wdata(d_wdata), .d_wnext(d_wnext),
        .i_rdata(i_rdata), .d_rdata(d_rdata), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
        .i_done(i_done), .d_done(d_done), .i_err(i_err), .d_err(d_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic test_reset();
        logic [6:0] acks;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        acks = {i_rvalid, d_rvalid, i_done, d_done, i_err, d_err, d_wnext};
        n_cmp++; if ({HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK, HWRITE} !== {2'b00, 3'b000, 3'b010, 4'b0011, 1'b0, 1'b0}) begin n_bad++; $display("FAIL reset_ctrl got %h", {HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK, HWRITE}); end
        n_cmp++; if ({HADDR, HWDATA} !== 64'h0) begin n_bad++; $display("FAIL reset_addr_data got %h %h want 0", HADDR, HWDATA); end
        n_cmp++; if ({acks, i_rdata, d_rdata} !== 71'h0) begin n_bad++; $display("FAIL reset_acks got %b %h %h want 0", acks, i_rdata, d_rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_d_single();
        int  done_cyc = -1;
        int  nval = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 32'h0000_1000; d_burst = 1'b0; d_write = 1'b0;
        HRDATA = 32'hDEAD_BEEF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++; if ({HTRANS, HBURST, HPROT, HWRITE} !== {2'b10, 3'b000, 4'b0011, 1'b0}) begin n_bad++; $display("FAIL dsingle_ctrl got %b want 10_000_0011_0", {HTRANS, HBURST, HPROT, HWRITE}); end
                n_cmp++; if (HADDR !== 32'h0000_1000) begin n_bad++; $display("FAIL dsingle_addr got %h want 00001000", HADDR); end
            end
            if (c == 3) begin
                n_cmp++; if ({d_rvalid, d_done, d_err, d_rdata} !== {3'b110, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL dsingle_resp got %b %h want 110 deadbeef", {d_rvalid, d_done, d_err}, d_rdata); end
            end
            if (d_rvalid) nval++;
            if (d_done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0) d_req = 1'b0;
        end
        n_cmp++; if (done_cyc != 3 || nval != 1) begin n_bad++; $display("FAIL dsingle_done got cyc %0d rvalids %0d want 3 1", done_cyc, nval); end
    endtask

    task automatic test_i_burst();
        int done_cyc = -1;
        int nval = 0;
        int bad_addr = 0;
        int bad_data = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0020; i_burst = 1'b1;
        for (int c = 0; c < 13; c++) begin
            HRDATA = 32'hA000_0000 | 32'(c);
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                if (HADDR !== 32'h20 + 32'(4 * (c - 1)) || HTRANS !== ((c == 1) ? 2'b10 : 2'b11) || HBURST !== 3'b101 || HPROT !== 4'b0010) begin
                    bad_addr++;
                    $display("FAIL iburst_addr c%0d got %h %b %b %b", c, HADDR, HTRANS, HBURST, HPROT);
                end
            end
            if (c == 9) begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL iburst_last_idle got %b want 00", HTRANS); end
            end
            if (i_rvalid) begin
                nval++;
                if (c < 3 || i_rdata !== (32'hA000_0000 | 32'(c - 1))) begin
                    bad_data++;
                    $display("FAIL iburst_rdata c%0d got %h want %h", c, i_rdata, 32'hA000_0000 | 32'(c - 1));
                end
            end
            if (i_done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0) i_req = 1'b0;
        end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL iburst_addr_phases got %0d bad cycles want 0", bad_addr); end
        n_cmp++; if (bad_data != 0 || nval != 8) begin n_bad++; $display("FAIL iburst_beats got %0d rvalids %0d bad want 8 0", nval, bad_data); end
        n_cmp++; if (done_cyc != 10) begin n_bad++; $display("FAIL iburst_done_cyc got %0d want 10", done_cyc); end
    endtask

    task automatic test_d_write_wait();
        int done_cyc = -1;
        int nwn = 0;
        int nval = 0;
        int bad_hold = 0;
        int bad_wd = 0;
        int wb = 0;
        int exp_beat;
        logic wn_seen;
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 32'h0000_0100; d_burst = 1'b1; d_write = 1'b1;
        d_wdata = 32'hB000_0000;
        for (int c = 0; c < 15; c++) begin
            HREADY = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            wn_seen = d_wnext;
            if (d_wnext) nwn++;
            if (d_rvalid) nval++;
            if (c >= 4 && c <= 6) begin
                if (HADDR !== 32'h0000_010C || HTRANS !== 2'b11 || HWRITE !== 1'b1) begin
                    bad_hold++;
                    $display("FAIL dwrite_hold c%0d got %h %b want 0000010c 11", c, HADDR, HTRANS);
                end
            end
            if (c >= 2 && c <= 11) begin
                exp_beat = (c <= 4) ? c - 2 : ((c <= 6) ? 2 : c - 4);
                if (HWDATA !== (32'hB000_0000 | 32'(exp_beat))) begin
                    bad_wd++;
                    $display("FAIL dwrite_hwdata c%0d got %h want %h", c, HWDATA, 32'hB000_0000 | 32'(exp_beat));
                end
            end
            if (d_done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
            if (wn_seen) begin
                wb++;
                d_wdata = 32'hB000_0000 | 32'(wb);
            end
            if (done_cyc >= 0) d_req = 1'b0;
        end
        HREADY = 1'b1;
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL dwrite_addr_hold got %0d bad cycles want 0", bad_hold); end
        n_cmp++; if (bad_wd != 0) begin n_bad++; $display("FAIL dwrite_hwdata_order got %0d bad cycles want 0", bad_wd); end
        n_cmp++; if (nwn != 8 || nval != 0) begin n_bad++; $display("FAIL dwrite_wnext got %0d wnext %0d rvalid want 8 0", nwn, nval); end
        n_cmp++; if (done_cyc != 12) begin n_bad++; $display("FAIL dwrite_done_cyc got %0d want 12", done_cyc); end
        d_write = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] prot_seq [4];
        int ngr = 0;
        int overlap = 0;
        int busy = 0;
        logic i_seen, d_seen;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        i_addr = 32'h0000_0200; i_burst = 1'b0;
        d_addr = 32'h0000_0300; d_burst = 1'b0; d_write = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (HTRANS == 2'b10) begin
                if (busy != 0) overlap++;
                busy = 1;
                if (ngr < 4) prot_seq[ngr] = HPROT;
                ngr++;
            end
            if (i_done && d_done) overlap++;
            if (i_done || d_done) busy = 0;
            i_seen = i_done; d_seen = d_done;
            @(posedge clk); #1;
            if (i_seen) i_req = 1'b0;
            if (d_seen) d_req = 1'b0;
            if (!i_req && !d_req && ngr < 4) begin i_req = 1'b1; d_req = 1'b1; end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++; if (ngr != 4) begin n_bad++; $display("FAIL rr_grant_count got %0d want 4", ngr); end
        else begin
            n_cmp++; if ({prot_seq[0], prot_seq[1], prot_seq[2], prot_seq[3]} !== 16'h3232) begin n_bad++; $display("FAIL rr_order got hprot %h want 3232 (D,I,D,I)", {prot_seq[0], prot_seq[1], prot_seq[2], prot_seq[3]}); end
        end
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL rr_overlap got %0d want 0", overlap); end
    endtask

    task automatic test_error();
        int done_cyc = -1;
        int nval = 0;
        logic err_at_done = 1'b0;
        int stray = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0040; i_burst = 1'b1;
        HRDATA = 32'h1234_5678;
        for (int c = 0; c < 11; c++) begin
            HREADY = (c == 4) ? 1'b0 : 1'b1;
            HRESP  = (c == 4 || c == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (c == 5) begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_idle_2nd got %b want 00", HTRANS); end
            end
            if (c > 6 && HTRANS !== 2'b00) stray++;
            if (i_rvalid) nval++;
            if (i_done && done_cyc < 0) begin done_cyc = c; err_at_done = i_err; end
            @(posedge clk); #1;
            if (done_cyc >= 0) i_req = 1'b0;
        end
        HREADY = 1'b1; HRESP = 1'b0;
        n_cmp++; if (done_cyc != 6 || err_at_done !== 1'b1) begin n_bad++; $display("FAIL err_done got cyc %0d err %b want 6 1", done_cyc, err_at_done); end
        n_cmp++; if (nval != 2) begin n_bad++; $display("FAIL err_rvalids got %0d want 2", nval); end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL err_back_idle got %0d active cycles want 0", stray); end
    endtask

    task automatic test_reset_mid_burst();
        int ndone = 0;
        int nact = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0080; i_burst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if ({HTRANS, i_rvalid, i_done, d_wnext, HADDR} !== {2'b00, 3'b000, 32'h0}) begin n_bad++; $display("FAIL rstmid_async got %b %b %h want 00 000 0", HTRANS, {i_rvalid, i_done, d_wnext}, HADDR); end
        i_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (i_done || d_done) ndone++;
            if (HTRANS !== 2'b00) nact++;
        end
        n_cmp++; if (ndone != 0 || nact != 0) begin n_bad++; $display("FAIL rstmid_after got %0d done %0d active want 0 0", ndone, nact); end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0; i_burst = 1'b0;
        d_req = 1'b0; d_addr = 32'h0; d_burst = 1'b0; d_write = 1'b0; d_wdata = 32'h0;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        test_reset();
        test_d_single();
        test_i_burst();
        test_d_write_wait();
        test_round_robin();
        test_error();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Merges the core's instruction-side (I-cache refill) and data-side (D-cache refill/writeback/uncached) memory requests onto the core's single AHB-Lite master port. Sits directly downstream of the cache/pipeline request logic and drives the core's HADDR/HTRANS/HBURST/HSIZE/HPROT/HWRITE/HWDATA outputs. Handles single-word transfers and fixed-length incrementing line bursts, with pipelined address/data phases, wait states and ERROR responses.

## Interface
- LINE_WORDS, 8: beats per burst request; 4, 8 or 16 only; selects HBURST INCR4/INCR8/INCR16.
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req, d_req  in  1  request; held high until matching *_done.
- i_addr, d_addr  in  32  start byte address; word-aligned; line-aligned (LINE_WORDS*4) when *_burst=1.
- i_burst, d_burst  in  1  0 = single word, 1 = LINE_WORDS-beat burst.
- d_write  in  1  1 = write (I side is read-only).
- d_wdata  in  32  current write beat; beat 0 valid with d_req.
- d_wnext  out  1  one-cycle pulse: current write beat taken, present next beat next cycle.
- i_rdata, d_rdata  out  32  read beat data.
- i_rvalid, d_rvalid  out  1  one-cycle pulse per read beat.
- i_done, d_done  out  1  one-cycle pulse: request finished (last beat or error).
- i_err, d_err  out  1  valid with *_done: transfer ended by HRESP=ERROR.
- HADDR out 32, HTRANS out 2, HBURST out 3, HSIZE out 3, HPROT out 4, HMASTLOCK out 1, HWRITE out 1, HWDATA out 32: AHB-Lite master outputs, all registered.
- HRDATA in 32, HREADY in 1, HRESP in 1: AHB-Lite slave responses.

## Operation
- FSM states: IDLE, XFER (address phase pending, possibly overlapped with previous data phase), LAST (final data phase only), ERR (second ERROR cycle).
- Arbitration in IDLE only; no preemption mid-transaction. Both pending: grant the side not granted last; after reset, D wins first tie. Single requester granted immediately.
- Grant latches side, address, burst, write; beat counter loaded with LINE_WORDS-1 or 0.
- Address phase: HTRANS=NONSEQ on beat 0, SEQ thereafter; HADDR +4 per accepted beat; HSIZE=3'b010 always; HBURST=SINGLE(000) or INCR4(011)/INCR8(101)/INCR16(111); HMASTLOCK=0; HPROT=4'b0010 for I side, 4'b0011 for D side.
- Address/control held constant while HREADY=0.
- Write: HWDATA registered from d_wdata when that beat's address phase is accepted (HREADY=1, HTRANS active); d_wnext pulses in that cycle.
- Read: when a data phase completes (HREADY=1, HRESP=0), HRDATA registered to *_rdata with *_rvalid pulse next cycle.
- After last address phase accepted: LAST with HTRANS=IDLE; completion of last data phase -> *_done pulse next cycle (coincident with final *_rvalid), return to IDLE.
- ERROR: HRESP=1 with HREADY=0 (first cycle) -> drive HTRANS=IDLE next cycle, go ERR; on the HREADY=1 cycle, *_done and *_err pulse next cycle; remaining beats dropped, no *_rvalid for errored beat.
- Requester must not drop *_req before *_done; if it does, the transfer still completes on the bus, and *_done still pulses.
- Reset mid-transfer: all outputs to reset values asynchronously; no *_done issued; bus left IDLE.

## Timing
- Reset values: HTRANS=00, HADDR=0, HBURST=000, HSIZE=010, HPROT=0011, HMASTLOCK=0, HWRITE=0, HWDATA=0; all *_rdata=0, *_rvalid/*_done/*_err/d_wnext=0; last-granted = I.
- Request at cycle 0 (FSM IDLE) -> NONSEQ on bus in cycle 1.
- Zero-wait single read: data phase cycle 2, *_rvalid+*_done cycle 3; next grant's NONSEQ earliest cycle 4.
- Zero-wait burst: one beat per cycle; N-beat burst -> *_done at cycle N+2.
- Each HREADY=0 cycle adds exactly one cycle.

## Structure
- Shared package ahb_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HSIZE_WORD, HPROT fetch/data constants, FSM state enum.
- Sub-module ahb_rr_arbiter: 2-input round-robin grant with last-granted register, evaluated only when FSM is IDLE.

## Test plan
- D single read 0x0000_1000, zero-wait, HRDATA=0xDEADBEEF -> NONSEQ/SINGLE/HPROT=0011 cycle 1; d_rvalid+d_done, d_rdata=0xDEADBEEF cycle 3.
- I burst at 0x0000_0020, LINE_WORDS=8 -> HBURST=101, HADDR 0x20..0x3C NONSEQ then 7 SEQ, 8 i_rvalid pulses, i_done at cycle 10.
- D write burst, HREADY low for 2 cycles on beat 3 -> HADDR/HTRANS held, HWDATA matches d_wdata beat order, 8 d_wnext pulses, d_done 2 cycles later than zero-wait.
- i_req and d_req asserted same cycle after reset, repeated -> grants D, I, D, I; no overlap on bus.
- HRESP ERROR on beat 2 of I burst -> HTRANS=IDLE in the second error cycle, i_done+i_err pulse, only 2 i_rvalid pulses, FSM IDLE.
- reset asserted mid-burst -> HTRANS=00 and all acks 0 immediately; no *_done after release.
